// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame sequencer: line mux selects,
// parity type values and the sequencer state enum.
package uart_tx_pkg;

    // Line mux select encodings.
    localparam logic [1:0] MUX_START = 2'd0;
    localparam logic [1:0] MUX_STOP  = 2'd1;
    localparam logic [1:0] MUX_DATA  = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;

    // Parity type values as seen on PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Accepts a byte handshake, pulses the
// serializer load, gates serializer shifting and steers the line mux through
// START -> DATA -> [PARITY] -> STOP (one or two stop bits). A byte offered in
// the final stop cycle is accepted directly, so frames can run back to back.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             STOP2,
    input  logic             ser_done,
    output logic             sample,
    output logic             ser_en,
    output logic [1:0]       mux_sel,
    output logic             par_bit,
    output logic             busy
);

    tx_state_t state_reg;
    tx_state_t state_next;
    logic      stop_cnt_reg;
    logic      stop_cnt_next;
    logic      par_en_reg;
    logic      stop2_reg;
    logic      par_bit_reg;
    logic      final_stop;
    logic      accept;

    // The last stop cycle is reached when the counter equals the captured
    // number of extra stop bits (0 for one stop bit, 1 for two).
    assign final_stop = (stop_cnt_reg == stop2_reg);
    assign sample     = accept;
    assign par_bit    = par_bit_reg;

    // State register and stop-bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            stop_cnt_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stop_cnt_reg <= stop_cnt_next;
        end
    end

    // Frame configuration and parity are frozen at accept for the whole frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_reg  <= 1'b0;
            stop2_reg   <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            par_en_reg  <= PAR_EN;
            stop2_reg   <= STOP2;
            par_bit_reg <= (^DATA) ^ PAR_TYP;
        end
    end

    // Next-state logic, Moore output decode and the Mealy accept/load pulse.
    always_comb begin
        state_next    = state_reg;
        stop_cnt_next = 1'b0;
        accept        = 1'b0;
        ser_en        = 1'b0;
        busy          = 1'b0;
        mux_sel       = MUX_STOP;
        case (state_reg)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    accept     = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                mux_sel    = MUX_START;
                busy       = 1'b1;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                mux_sel = MUX_DATA;
                ser_en  = 1'b1;
                busy    = 1'b1;
                if (ser_done) begin
                    state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                mux_sel    = MUX_PAR;
                busy       = 1'b1;
                state_next = ST_STOP;
            end
            ST_STOP: begin
                busy = 1'b1;
                if (final_stop) begin
                    if (DATA_VALID) begin
                        accept     = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    stop_cnt_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. A frame-level model turns each accepted byte into
// the list of line symbols the frame must produce; every cycle the DUT
// outputs are compared against the head of that list.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] DATA = '0;
    logic             DATA_VALID = 1'b0;
    logic             PAR_EN = 1'b0;
    logic             PAR_TYP = 1'b0;
    logic             STOP2 = 1'b0;
    logic             ser_done = 1'b0;
    logic             sample;
    logic             ser_en;
    logic [1:0]       mux_sel;
    logic             par_bit;
    logic             busy;

    uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .ser_done(ser_done),
        .sample(sample), .ser_en(ser_en), .mux_sel(mux_sel), .par_bit(par_bit),
        .busy(busy)
    );

    initial forever #5 CLK = ~CLK;

    // One line-cycle of a frame: mux value, shift enable, busy, whether a
    // new byte may be accepted in it, and whether it is the last data bit.
    typedef struct packed {
        logic [1:0] mux;
        logic       en;
        logic       bsy;
        logic       fin;
        logic       last;
    } ent_t;

    ent_t cur;
    ent_t q[$];
    logic exp_par;
    int   acc_cnt = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    int   cyc = 0;
    int   cnt_busy, cnt_en, cnt_samp, cnt_stop, cnt_par, first_b, last_b;

    function automatic ent_t mk(logic [1:0] m, logic e, logic b, logic f, logic l);
        ent_t r;
        r.mux = m; r.en = e; r.bsy = b; r.fin = f; r.last = l;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        tot_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    endtask

    task automatic model_reset();
        q.delete();
        cur = mk(MUX_STOP, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_par = 1'b0;
    endtask

    task automatic model_step();
        if (DATA_VALID && cur.fin) begin
            q.delete();
            q.push_back(mk(MUX_START, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i < WIDTH; i++)
                q.push_back(mk(MUX_DATA, 1'b1, 1'b1, 1'b0, i == WIDTH - 1));
            if (PAR_EN) q.push_back(mk(MUX_PAR, 1'b0, 1'b1, 1'b0, 1'b0));
            q.push_back(mk(MUX_STOP, 1'b0, 1'b1, !STOP2, 1'b0));
            if (STOP2) q.push_back(mk(MUX_STOP, 1'b0, 1'b1, 1'b1, 1'b0));
            exp_par = (($countones(DATA) % 2) == 1) ^ PAR_TYP;
            acc_cnt++;
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = mk(MUX_STOP, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Model advance on every clock edge; asynchronous reset clears it.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else model_step();
        end
    end

    // Matching serializer: ser_done on the last data bit, random noise
    // whenever the frame is not in its data phase.
    initial forever begin
        @(negedge CLK);
        if (cur.mux == MUX_DATA && cur.bsy) ser_done = cur.last;
        else ser_done = 1'($urandom_range(0, 1));
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        logic exp_samp;
        @(negedge CLK);
        #2;
        cyc++;
        exp_samp = DATA_VALID && cur.fin;
        chk("mux_sel", mux_sel, cur.mux);
        chk("ser_en", ser_en, cur.en);
        chk("busy", busy, cur.bsy);
        chk("par_bit", par_bit, exp_par);
        chk("sample", sample, exp_samp);
        if (cur.bsy) begin
            cnt_busy++;
            if (first_b < 0) first_b = cyc;
            last_b = cyc;
        end
        if (cur.en) cnt_en++;
        if (exp_samp) cnt_samp++;
        if (cur.bsy && cur.mux == MUX_STOP) cnt_stop++;
        if (cur.mux == MUX_PAR) cnt_par++;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clr();
        cnt_busy = 0; cnt_en = 0; cnt_samp = 0; cnt_stop = 0; cnt_par = 0;
        first_b = -1; last_b = -1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic s2, input int frames);
        int a0;
        a0 = acc_cnt;
        DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 50 * frames && acc_cnt < a0 + frames; i++) tick();
        if (acc_cnt < a0 + frames) chk("accept_timeout", acc_cnt - a0, frames);
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && cur.bsy; i++) tick();
        if (cur.bsy) chk("idle_timeout", 1, 0);
        tick();
        tick();
    endtask

    initial begin
        clr();
        #1 RST = 1'b1;
        tick(); tick(); tick();
        RST = 1'b0;

        // Idle after reset.
        clr();
        repeat (20) tick();
        chk("idle_busy_cycles", cnt_busy, 0);
        chk("idle_sample_cycles", cnt_samp, 0);

        // Plain 8N1 frame.
        clr();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1);
        wait_idle();
        chk("a5_busy_cycles", cnt_busy, 10);
        chk("a5_ser_en_cycles", cnt_en, 8);
        chk("a5_sample_cycles", cnt_samp, 1);
        chk("a5_stop_cycles", cnt_stop, 1);

        // Even parity on 0x07 -> 1.
        clr();
        send(8'h07, 1'b1, PAR_EVEN, 1'b0, 1);
        wait_idle();
        chk("even_par_bit", par_bit, 1);
        chk("even_par_cycles", cnt_par, 1);
        chk("even_busy_cycles", cnt_busy, 11);

        // Odd parity on 0x07 -> 0.
        clr();
        send(8'h07, 1'b1, PAR_ODD, 1'b0, 1);
        wait_idle();
        chk("odd_par_bit", par_bit, 0);

        // Two stop bits with parity: 12 busy cycles.
        clr();
        send(8'h07, 1'b1, PAR_EVEN, 1'b1, 1);
        wait_idle();
        chk("stop2_stop_cycles", cnt_stop, 2);
        chk("stop2_busy_cycles", cnt_busy, 12);

        // Three back-to-back frames with DATA_VALID held.
        clr();
        send(8'h3C, 1'b1, PAR_EVEN, 1'b1, 3);
        wait_idle();
        chk("b2b_samples", cnt_samp, 3);
        chk("b2b_busy_cycles", cnt_busy, 36);
        chk("b2b_busy_contiguous", last_b - first_b + 1, 36);

        // PAR_EN dropped mid-frame: this frame keeps its parity bit.
        clr();
        send(8'h07, 1'b1, PAR_EVEN, 1'b0, 1);
        tick(); tick(); tick();
        PAR_EN = 1'b0;
        wait_idle();
        chk("cfg_hold_par_cycles", cnt_par, 1);
        chk("cfg_hold_busy_cycles", cnt_busy, 11);
        clr();
        send(8'h07, 1'b0, PAR_EVEN, 1'b0, 1);
        wait_idle();
        chk("next_frame_par_cycles", cnt_par, 0);
        chk("next_frame_busy_cycles", cnt_busy, 10);

        // Reset pulse in the 4th data cycle.
        clr();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1);
        tick(); tick(); tick(); tick();
        RST = 1'b1;
        #3;
        chk("rst_mux_sel", mux_sel, MUX_STOP);
        chk("rst_busy", busy, 0);
        chk("rst_ser_en", ser_en, 0);
        chk("rst_par_bit", par_bit, 0);
        chk("rst_data_cycles_seen", cnt_en, 3);
        tick();
        RST = 1'b0;
        tick();
        clr();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1);
        wait_idle();
        chk("post_rst_busy_cycles", cnt_busy, 10);
        chk("post_rst_ser_en_cycles", cnt_en, 8);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a byte handshake, pulses the serializer load, and gates the serializer shift. It walks START -> DATA -> PARITY -> STOP states and drives the output mux select. It also computes the parity bit at accept time, supports one or two stop bits, and allows back-to-back frames with no idle gap.

Parameters:
WIDTH, 8, data word width; must match the serializer WIDTH.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
DATA  input  WIDTH  parallel byte; used only for parity computation at accept.
DATA_VALID  input  1  byte-available strobe; accepted per the rules below.
PAR_EN  input  1  1 = parity bit inserted after data.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
ser_done  input  1  serializer signals that the last data bit is on ser_data this cycle.
sample  output  1  serializer load pulse; high exactly in the accept cycle.
ser_en  output  1  serializer shift enable.
mux_sel  output  2  line mux select, encoded START=0, STOP=1, DATA=2, PARITY=3.
par_bit  output  1  registered parity bit, held for the whole frame.
busy  output  1  high from the cycle after accept until frame end.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE, sample=0, ser_en=0, mux_sel=STOP (line idles high), par_bit=0, busy=0, stop counter 0.
  - A reset mid-frame aborts immediately; no partial stop bit is sent.
- States: IDLE, START, DATA, PARITY, STOP.
- Outputs are Moore (decoded from the state register), except sample, which is Mealy.
- Accept condition: DATA_VALID=1 while (state==IDLE) or (state==STOP and it is the final stop cycle).
  - On accept, sample=1 in that same cycle.
  - On accept, PAR_EN, PAR_TYP and STOP2 are captured into config registers.
  - On accept, par_bit <= ^DATA ^ PAR_TYP.
  - Next state is START.
- DATA_VALID in any other cycle is ignored; no queuing. The upstream FIFO must hold DATA_VALID until sample is seen.
- IDLE: mux_sel=STOP, ser_en=0, busy=0.
- START: one cycle. mux_sel=START, ser_en=0, busy=1. Always goes to DATA.
- DATA: mux_sel=DATA, ser_en=1, busy=1.
  - Stays until ser_done=1 is sampled.
  - Then goes to PARITY if captured PAR_EN=1, else to STOP.
  - With the matching serializer this lasts exactly WIDTH cycles.
- PARITY: one cycle. mux_sel=PARITY, ser_en=0. Goes to STOP.
- STOP: mux_sel=STOP, ser_en=0.
  - Lasts 1 cycle, or 2 cycles if captured STOP2=1, using a 1-bit stop counter.
  - In the final stop cycle: accept -> START, else -> IDLE.
  - busy stays 1 throughout STOP.
- Frame length in cycles: 1 + WIDTH + PAR_EN + 1 + STOP2.
  - WIDTH=8 gives 10, 11 or 12.
- Config inputs that change mid-frame have no effect until the next accept.
- par_bit is unchanged until the next accept.
- ser_done outside DATA is ignored.
- ser_en never asserts outside DATA. sample and ser_en are never high in the same cycle.

Decomposition:
- Package uart_tx_pkg holds:
  - mux_sel encodings MUX_START=2'd0, MUX_STOP=2'd1, MUX_DATA=2'd2, MUX_PAR=2'd3;
  - the state enum/localparams;
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
- No sub-module: the parity XOR-reduce is a single expression, and the FSM, config registers and stop counter live in one module.
- The existing serializer, parity-free line mux and top-level wrapper instantiate this block.

Test Plan:
- Reset release, DATA_VALID=0 for 20 cycles -> mux_sel=1, busy=0, ser_en=0, sample=0 throughout.
- DATA=8'hA5, PAR_EN=0, STOP2=0, one-cycle DATA_VALID in IDLE, ser_done modelled at the 8th DATA cycle ->
  - sample pulse in the accept cycle;
  - then mux_sel sequence 0, 2×8, 1, then IDLE;
  - ser_en high exactly 8 cycles;
  - busy high 10 cycles.
- DATA=8'h07, PAR_EN=1, PAR_TYP=0 -> par_bit=1 and a PARITY cycle follows DATA. Repeat with PAR_TYP=1 -> par_bit=0. STOP2=1 -> two mux_sel=1 cycles; total busy 12 cycles.
- DATA_VALID held continuously for three frames -> sample asserts in each final stop cycle, START follows directly, busy never drops, no IDLE cycle between frames.
- PAR_EN toggled 1->0 during DATA of a parity frame -> PARITY state still entered for that frame; the next frame has no parity.
- RST pulsed for 1 cycle during the 4th DATA cycle -> asynchronous return to IDLE values (mux_sel=1, busy=0, ser_en=0). A new DATA_VALID afterwards starts a clean frame.
